// File: rtl/mult_pkg.sv
// Shared types for the sequential multiplier: controller states and per-step datapath ops.
package mult_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    OpNop,
    OpAdd,
    OpSub
  } step_op_e;

  // Unsigned mode adds M on Q[0]; Booth mode recodes the {Q[0], q_1} pair.
  function automatic step_op_e step_op(input logic q0, input logic q_1, input logic signed_mode);
    step_op_e op;
    op = OpNop;
    if (!signed_mode) begin
      if (q0) op = OpAdd;
    end else begin
      unique case ({q0, q_1})
        2'b01:   op = OpAdd;
        2'b10:   op = OpSub;
        default: op = OpNop;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/mult_step.sv
// One multiply iteration: optional add/subtract of M into A, then a right shift of {A, Q, q_1}.
module mult_step
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic             q_1,
  input  logic [WIDTH:0]   m,
  input  step_op_e         op,
  input  logic             signed_mode,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_1_next
);

  logic [WIDTH:0] sum;
  logic           fill;

  always_comb begin
    sum = a;
    unique case (op)
      OpAdd:   sum = a + m;
      OpSub:   sum = a - m;
      default: sum = a;
    endcase
  end

  // Unsigned shifts in zero (carry already sits in sum[WIDTH]); Booth replicates the sign.
  assign fill     = signed_mode ? sum[WIDTH] : 1'b0;
  assign a_next   = {fill, sum[WIDTH:1]};
  assign q_next   = {sum[0], q[WIDTH-1:1]};
  assign q_1_next = q[0];

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle WIDTH x WIDTH multiplier, unsigned shift-add or radix-2 Booth, one step per clock.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SIGNED_MODE = 0
) (
  input  logic               clk,
  input  logic               areset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CntW       = $clog2(WIDTH + 1);
  localparam logic        SignedMode = (SIGNED_MODE != 0);

  state_e             state_q, state_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH:0]     m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q1_q, q1_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  step_op_e         op;
  logic [WIDTH:0]   a_next;
  logic [WIDTH-1:0] q_next;
  logic             q_1_next;
  logic             accept;

  assign op = step_op(q_q[0], q1_q, SignedMode);

  mult_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .a          (a_q),
    .q          (q_q),
    .q_1        (q1_q),
    .m          (m_q),
    .op         (op),
    .signed_mode(SignedMode),
    .a_next     (a_next),
    .q_next     (q_next),
    .q_1_next   (q_1_next)
  );

  assign accept = start && (state_q == StIdle || state_q == StDone);

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    m_d       = m_q;
    q_d       = q_q;
    q1_d      = q1_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    unique case (state_q)
      StIdle:  if (start) state_d = StCalc;
      StCalc: begin
        a_d   = a_next;
        q_d   = q_next;
        q1_d  = q_1_next;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d   = StDone;
          product_d = {a_next[WIDTH-1:0], q_next};
        end
      end
      StDone:  state_d = start ? StCalc : StIdle;
      default: state_d = StIdle;
    endcase

    // product is deliberately left alone on accept so it holds through the next CALC.
    if (accept) begin
      a_d   = '0;
      q_d   = multiplier;
      q1_d  = 1'b0;
      m_d   = {SignedMode & multiplicand[WIDTH-1], multiplicand};
      cnt_d = CntW'(WIDTH);
    end
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q   <= StIdle;
      a_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      m_q       <= m_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == StCalc);
  assign done    = (state_q == StDone);
  assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: 8-bit unsigned, 8-bit Booth and 16-bit Booth instances.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  logic        start_u8, start_s8, start_s16;
  logic [7:0]  mc_u8, mp_u8, mc_s8, mp_s8;
  logic [15:0] mc_s16, mp_s16;
  logic        busy_u8, busy_s8, busy_s16;
  logic        done_u8, done_s8, done_s16;
  logic [15:0] prod_u8, prod_s8;
  logic [31:0] prod_s16;

  int checks = 0;
  int errors = 0;

  seq_multiplier #(.WIDTH(8), .SIGNED_MODE(0)) u_u8 (
    .clk(clk), .areset(areset), .start(start_u8), .multiplicand(mc_u8), .multiplier(mp_u8),
    .busy(busy_u8), .done(done_u8), .product(prod_u8)
  );

  seq_multiplier #(.WIDTH(8), .SIGNED_MODE(1)) u_s8 (
    .clk(clk), .areset(areset), .start(start_s8), .multiplicand(mc_s8), .multiplier(mp_s8),
    .busy(busy_s8), .done(done_s8), .product(prod_s8)
  );

  seq_multiplier #(.WIDTH(16), .SIGNED_MODE(1)) u_s16 (
    .clk(clk), .areset(areset), .start(start_s16), .multiplicand(mc_s16), .multiplier(mp_s16),
    .busy(busy_s16), .done(done_s16), .product(prod_s16)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? busy_u8 : (sel == 1) ? busy_s8 : busy_s16;
  endfunction

  function automatic logic done_of(input int sel);
    return (sel == 0) ? done_u8 : (sel == 1) ? done_s8 : done_s16;
  endfunction

  function automatic logic [31:0] prod_of(input int sel);
    return (sel == 0) ? {16'h0, prod_u8} : (sel == 1) ? {16'h0, prod_s8} : prod_s16;
  endfunction

  // Pulse start for one accept edge; lat counts edges from the accept edge to done high.
  task automatic run(input int sel, input logic [15:0] a, input logic [15:0] b,
                     output int lat, output int bcnt, output logic [31:0] prod);
    case (sel)
      0:       begin start_u8 = 1'b1; mc_u8 = a[7:0]; mp_u8 = b[7:0]; end
      1:       begin start_s8 = 1'b1; mc_s8 = a[7:0]; mp_s8 = b[7:0]; end
      default: begin start_s16 = 1'b1; mc_s16 = a; mp_s16 = b; end
    endcase
    lat  = 0;
    bcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start_u8  = 1'b0;
      start_s8  = 1'b0;
      start_s16 = 1'b0;
      if (busy_of(sel)) bcnt++;
      if (done_of(sel)) break;
    end
    prod = prod_of(sel);
  endtask

  int          lat, bcnt, ndone, done_at, d1, d2;
  logic [31:0] prod, p1, p2;

  initial begin
    areset = 1'b1;
    start_u8 = 1'b0; start_s8 = 1'b0; start_s16 = 1'b0;
    mc_u8 = '0; mp_u8 = '0; mc_s8 = '0; mp_s8 = '0; mc_s16 = '0; mp_s16 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_busy", 64'(busy_u8), 64'd0);
    check_eq("reset_done", 64'(done_u8), 64'd0);
    check_eq("reset_product", 64'(prod_u8), 64'd0);
    areset = 1'b0;
    @(negedge clk);

    // Unsigned corner cases
    run(0, 16'd255, 16'd255, lat, bcnt, prod);
    check_eq("u8_255x255", 64'(prod), 64'hFE01);
    check_eq("u8_latency", 64'(lat), 64'd9);
    check_eq("u8_busy_cycles", 64'(bcnt), 64'd8);
    @(negedge clk);
    check_eq("u8_done_one_cycle", 64'(done_u8), 64'd0);
    check_eq("u8_product_held_idle", 64'(prod_u8), 64'hFE01);
    run(0, 16'd0, 16'd200, lat, bcnt, prod);
    check_eq("u8_0x200", 64'(prod), 64'h0000);

    // Booth corner cases
    run(1, 16'h0080, 16'h0080, lat, bcnt, prod);
    check_eq("s8_m128xm128", 64'(prod), 64'h4000);
    run(1, 16'h0080, 16'h007F, lat, bcnt, prod);
    check_eq("s8_m128x127", 64'(prod), 64'hC080);
    run(1, 16'h00FF, 16'h0001, lat, bcnt, prod);
    check_eq("s8_m1x1", 64'(prod), 64'hFFFF);
    run(1, 16'h0005, 16'h00FD, lat, bcnt, prod);
    check_eq("s8_5xm3", 64'(prod), 64'hFFF1);
    run(2, 16'h8000, 16'h7FFF, lat, bcnt, prod);
    check_eq("s16_8000x7fff", 64'(prod), 64'hC0008000);
    check_eq("s16_latency", 64'(lat), 64'd17);

    // Start pulsed mid-CALC with other operands must be ignored
    start_u8 = 1'b1; mc_u8 = 8'd20; mp_u8 = 8'd30;
    ndone = 0; done_at = 0; prod = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      start_u8 = (i == 3);
      if (i == 3) begin mc_u8 = 8'd5; mp_u8 = 8'd6; end
      if (done_u8) begin
        ndone++;
        if (ndone == 1) begin done_at = i; prod = 32'(prod_u8); end
      end
    end
    start_u8 = 1'b0;
    check_eq("ignore_start_product", 64'(prod), 64'd600);
    check_eq("ignore_start_done_edge", 64'(done_at), 64'd9);
    check_eq("ignore_start_done_count", 64'(ndone), 64'd1);

    // Reset mid-CALC aborts with no done
    start_u8 = 1'b1; mc_u8 = 8'd100; mp_u8 = 8'd100;
    @(posedge clk);
    @(negedge clk);
    start_u8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    areset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    areset = 1'b0;
    check_eq("abort_busy", 64'(busy_u8), 64'd0);
    check_eq("abort_done", 64'(done_u8), 64'd0);
    check_eq("abort_product", 64'(prod_u8), 64'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_u8) ndone++;
    end
    check_eq("abort_no_done", 64'(ndone), 64'd0);
    run(0, 16'd12, 16'd13, lat, bcnt, prod);
    check_eq("after_abort_12x13", 64'(prod), 64'd156);
    check_eq("after_abort_latency", 64'(lat), 64'd9);

    // Start held high: back-to-back operations
    start_u8 = 1'b1; mc_u8 = 8'd3; mp_u8 = 8'd5;
    ndone = 0; d1 = 0; d2 = 0; p1 = '0; p2 = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      mc_u8 = 8'd7; mp_u8 = 8'd9;
      if (done_u8) begin
        ndone++;
        if (ndone == 1) begin d1 = i; p1 = 32'(prod_u8); end
        else if (ndone == 2) begin d2 = i; p2 = 32'(prod_u8); end
      end
    end
    start_u8 = 1'b0;
    check_eq("b2b_done_count", 64'(ndone), 64'd2);
    check_eq("b2b_first_edge", 64'(d1), 64'd9);
    check_eq("b2b_spacing", 64'(d2 - d1), 64'd9);
    check_eq("b2b_first_product", 64'(p1), 64'd15);
    check_eq("b2b_second_product", 64'(p2), 64'd63);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
